// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared TPL DAC definitions: scheduler FSM states, the select-code width
// and the default select code applied out of reset.
package ad_ip_jesd204_tpl_dac_pkg;

  localparam int SEL_WIDTH = 4;
  localparam logic [SEL_WIDTH-1:0] DEFAULT_RESET_SEL = 4'h0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } sched_state_t;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_src_sched_if.sv
// Request channel from the (link_clk-synchronised) register map into the
// source scheduler: valid/ready handshake, per-channel select codes,
// sync-on-apply flag, boundary delay and abort.
interface ad_ip_jesd204_tpl_dac_src_sched_if
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int DELAY_WIDTH  = 8
) ();

  logic                              req_valid;
  logic                              req_ready;
  logic [NUM_CHANNELS*SEL_WIDTH-1:0] req_sel;
  logic                              req_sync;
  logic [DELAY_WIDTH-1:0]            req_delay;
  logic                              abort;

  modport master (
    output req_valid, req_sel, req_sync, req_delay, abort,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_sel, req_sync, req_delay, abort,
    output req_ready
  );

endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_mf_counter.sv
// Multiframe beat counter. Counts link beats while the link is ready, holds
// at beat 0 while it is not, and flags the last beat of each multiframe.
// Shared between the DAC and ADC transport layers.
module ad_ip_jesd204_tpl_dac_mf_counter #(
  parameter int BEATS_PER_MF = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic i_link_ready,
  output logic o_mf_boundary
);

  localparam int CNT_W = $clog2(BEATS_PER_MF);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_MF - 1);

  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_beat_cnt_next;
  logic             r_mf_boundary;

  // Next beat: advance and wrap while the link is ready, otherwise back to 0.
  always_comb begin
    w_beat_cnt_next = '0;
    if (i_link_ready && (r_beat_cnt != LAST_BEAT)) begin
      w_beat_cnt_next = r_beat_cnt + 1'b1;
    end
  end

  // The boundary flag is registered by predicting the next beat, so it is
  // high exactly while the counter sits on the last beat of a multiframe
  // that was reached with the link ready.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_beat_cnt    <= '0;
      r_mf_boundary <= 1'b0;
    end else begin
      r_beat_cnt    <= w_beat_cnt_next;
      r_mf_boundary <= i_link_ready && (w_beat_cnt_next == LAST_BEAT);
    end
  end

  assign o_mf_boundary = r_mf_boundary;

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_src_sched.sv
// DAC data-source scheduler (link_clk domain). Latches a per-channel select
// request and applies it to all channels on the same beat, at a multiframe
// boundary, optionally pulsing the DDS phase reset.
// Optional feature macro: ADI_TPL_DAC_SRC_SCHED_STATS_EN adds o_apply_count.
module ad_ip_jesd204_tpl_dac_src_sched
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int                   NUM_CHANNELS = 2,
  parameter int                   BEATS_PER_MF = 16,
  parameter int                   DELAY_WIDTH  = 8,
  parameter logic [SEL_WIDTH-1:0] RESET_SEL    = DEFAULT_RESET_SEL
) (
  input  logic                              clk,
  input  logic                              srst,
  input  logic                              i_link_ready,
  ad_ip_jesd204_tpl_dac_src_sched_if.slave  req_if,
  output logic [NUM_CHANNELS*SEL_WIDTH-1:0] o_dac_data_sel,
  output logic                              o_dac_sync,
  output logic                              o_mf_boundary,
  output logic                              o_applied,
  output logic                              o_busy
`ifdef ADI_TPL_DAC_SRC_SCHED_STATS_EN
  ,
  output logic [15:0]                       o_apply_count
`endif
);

  localparam int SEL_TOT = NUM_CHANNELS * SEL_WIDTH;

  sched_state_t           r_state;
  logic [SEL_TOT-1:0]     r_sel_latched;
  logic                   r_sync_latched;
  logic [DELAY_WIDTH-1:0] r_remaining;
  logic [SEL_TOT-1:0]     r_dac_data_sel;
  logic                   r_dac_sync;
  logic                   r_applied;
  logic                   r_busy;
  logic                   r_req_ready;
  logic [SEL_TOT-1:0]     w_reset_sel;
  logic                   w_mf_boundary;
  logic                   w_accept;
  logic                   w_apply;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_reset_sel
    assign w_reset_sel[gi*SEL_WIDTH +: SEL_WIDTH] = RESET_SEL;
  end

  ad_ip_jesd204_tpl_dac_mf_counter #(
    .BEATS_PER_MF (BEATS_PER_MF)
  ) u_mf_counter (
    .clk           (clk),
    .srst          (srst),
    .i_link_ready  (i_link_ready),
    .o_mf_boundary (w_mf_boundary)
  );

  // Acceptance uses the registered ready so nothing is taken while it is low.
  // An abort on the final boundary suppresses the apply.
  assign w_accept = (r_state == IDLE) && r_req_ready && req_if.req_valid;
  assign w_apply  = (r_state == ARMED) && w_mf_boundary && !req_if.abort &&
                    (r_remaining == '0);

  // Scheduler FSM with registered handshake and apply outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state        <= IDLE;
      r_sel_latched  <= w_reset_sel;
      r_sync_latched <= 1'b0;
      r_remaining    <= '0;
      r_dac_data_sel <= w_reset_sel;
      r_dac_sync     <= 1'b0;
      r_applied      <= 1'b0;
      r_busy         <= 1'b0;
      r_req_ready    <= 1'b0;
    end else begin
      r_dac_sync <= 1'b0;
      r_applied  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sel_latched  <= req_if.req_sel;
            r_sync_latched <= req_if.req_sync;
            r_remaining    <= req_if.req_delay;
            r_state        <= ARMED;
            r_req_ready    <= 1'b0;
            r_busy         <= 1'b1;
          end else begin
            r_req_ready    <= 1'b1;
            r_busy         <= 1'b0;
          end
        end
        ARMED: begin
          if (req_if.abort) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else if (w_apply) begin
            r_dac_data_sel <= r_sel_latched;
            r_dac_sync     <= r_sync_latched;
            r_applied      <= 1'b1;
            r_state        <= IDLE;
            r_req_ready    <= 1'b1;
            r_busy         <= 1'b0;
          end else if (w_mf_boundary) begin
            r_remaining <= r_remaining - 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign req_if.req_ready = r_req_ready;
  assign o_dac_data_sel   = r_dac_data_sel;
  assign o_dac_sync       = r_dac_sync;
  assign o_applied        = r_applied;
  assign o_busy           = r_busy;
  assign o_mf_boundary    = w_mf_boundary;

`ifdef ADI_TPL_DAC_SRC_SCHED_STATS_EN
  logic [15:0] r_apply_count;

  // Saturating count of applied requests; aborts are not counted.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_apply_count <= 16'd0;
    end else if (w_apply && (r_apply_count != 16'hFFFF)) begin
      r_apply_count <= r_apply_count + 16'd1;
    end
  end

  assign o_apply_count = r_apply_count;
`endif

endmodule
